calc_req_driver: RTL and testbench

Single-channel request driver placed directly upstream of one calc1_top request port. It accepts whole calculator transactions (command, operand 1, operand 2) through a valid/ready interface and buffers them in a small FIFO. It serialises each transaction onto the port's two-cycle cmd/data protocol and watches the matching response port with a timeout. Each outcome is returned as one result beat on a valid/ready interface.

---
 rtl/calc_req_driver.sv | 180 ++++++++++++++++++
 tb/tb_calc_req_driver.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_req_driver.sv
// calc_req_driver: buffers whole calculator transactions, serialises each onto one
// calc1_top request port (cmd/op1 then op2) and returns the response or a timeout.
module calc_req_driver #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 10
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cmd,
   input  logic [31:0] in_op1,
   input  logic [31:0] in_op2,
   output logic [3:0]  req_cmd_out,
   output logic [31:0] req_data_out,
   input  logic [1:0]  out_resp,
   input  logic [31:0] out_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [1:0]  res_resp,
   output logic [31:0] res_data,
   output logic        res_timeout,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
   // valid never waits for ready, and the source holds its payload stable until then.

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEND1 = 3'd1,
      S_SEND2 = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [3:0]  fifo_cmd [FIFO_DEPTH];
   logic [31:0] fifo_op1 [FIFO_DEPTH];
   logic [31:0] fifo_op2 [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop;

   logic [3:0]    cur_cmd, cur_cmd_d;
   logic [31:0]   cur_op2, cur_op2_d;
   logic [CW-1:0] wait_cnt, wait_cnt_d;
   logic [3:0]    req_cmd_d;
   logic [31:0]   req_data_d;
   logic          res_valid_d, res_timeout_d;
   logic [1:0]    res_resp_d;
   logic [31:0]   res_data_d;

   assign in_ready  = (count != DEPTH_C);
   assign push      = in_valid & in_ready;
   assign pop       = (state == S_IDLE) && (count != '0);
   assign busy      = (state != S_IDLE) || (count != '0);
   assign dbg_state = state;

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge c_clk) begin
      if (push) begin
         fifo_cmd[wr_ptr] <= in_cmd;
         fifo_op1[wr_ptr] <= in_op1;
         fifo_op2[wr_ptr] <= in_op2;
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cur_cmd      <= '0;
         cur_op2      <= '0;
         wait_cnt     <= '0;
         req_cmd_out  <= '0;
         req_data_out <= '0;
         res_valid    <= 1'b0;
         res_resp     <= '0;
         res_data     <= '0;
         res_timeout  <= 1'b0;
      end else begin
         state        <= state_nx;
         cur_cmd      <= cur_cmd_d;
         cur_op2      <= cur_op2_d;
         wait_cnt     <= wait_cnt_d;
         req_cmd_out  <= req_cmd_d;
         req_data_out <= req_data_d;
         res_valid    <= res_valid_d;
         res_resp     <= res_resp_d;
         res_data     <= res_data_d;
         res_timeout  <= res_timeout_d;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (count != '0) state_nx = S_SEND1;
         S_SEND1: state_nx = S_SEND2;
         S_SEND2: state_nx = (cur_cmd == 4'h0) ? S_HOLD : S_WAIT;
         S_WAIT:  if (out_resp != 2'b00 || wait_cnt == TMAX) state_nx = S_HOLD;
         S_HOLD:  if (res_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Request lines default to zero every cycle; result fields hold until reloaded.
   always_comb begin
      req_cmd_d     = 4'h0;
      req_data_d    = 32'h0;
      cur_cmd_d     = cur_cmd;
      cur_op2_d     = cur_op2;
      wait_cnt_d    = wait_cnt;
      res_valid_d   = res_valid;
      res_resp_d    = res_resp;
      res_data_d    = res_data;
      res_timeout_d = res_timeout;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               req_cmd_d  = fifo_cmd[rd_ptr];
               req_data_d = fifo_op1[rd_ptr];
               cur_cmd_d  = fifo_cmd[rd_ptr];
               cur_op2_d  = fifo_op2[rd_ptr];
            end
         end
         S_SEND1: req_data_d = cur_op2;
         S_SEND2: begin
            wait_cnt_d = '0;
            if (cur_cmd == 4'h0) begin
               res_valid_d   = 1'b1;
               res_resp_d    = 2'b00;
               res_data_d    = 32'h0;
               res_timeout_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (out_resp != 2'b00) begin
               res_valid_d   = 1'b1;
               res_resp_d    = out_resp;
               res_data_d    = out_data;
               res_timeout_d = 1'b0;
            end else if (wait_cnt == TMAX) begin
               res_valid_d   = 1'b1;
               res_resp_d    = 2'b00;
               res_data_d    = 32'h0;
               res_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt + 1'b1;
            end
         end
         S_HOLD: if (res_ready) res_valid_d = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_calc_req_driver.sv
// Bench for calc_req_driver: a behavioural calc1_top responder plus a transaction-level
// expectation of every result beat and request sequence.
module tb_calc_req_driver;

   localparam int TIMEOUT = 10;

   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_cmd = 4'h0;
   logic [31:0] in_op1 = 32'h0;
   logic [31:0] in_op2 = 32'h0;
   logic [3:0]  req_cmd_out;
   logic [31:0] req_data_out;
   logic [1:0]  out_resp = 2'b00;
   logic [31:0] out_data = 32'h0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [1:0]  res_resp;
   logic [31:0] res_data;
   logic        res_timeout;
   logic        busy;
   logic [2:0]  dbg_state;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int stray_a = -1;
   int stray_b = -1;

   logic [34:0] exp_q[$];
   logic [34:0] got_q[$];
   logic [67:0] exp_req_q[$];
   logic [67:0] act_req_q[$];
   int          lat_q[$];

   calc_req_driver #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
      .c_clk(c_clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
      .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
      .out_resp(out_resp), .out_data(out_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_resp(res_resp), .res_data(res_data), .res_timeout(res_timeout),
      .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 c_clk = ~c_clk;
   always @(posedge c_clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Stand-in calculator: 1 add, 2 subtract, anything else invalid.
   function automatic logic [33:0] calc_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [32:0] s;
      case (c)
         4'd1: begin
            s = {1'b0, a} + {1'b0, b};
            return s[32] ? {2'b10, 32'h0} : {2'b01, s[31:0]};
         end
         4'd2: begin
            s = {1'b0, a} - {1'b0, b};
            return (b > a) ? {2'b10, 32'h0} : {2'b01, s[31:0]};
         end
         default: return {2'b11, 32'h0};
      endcase
   endfunction

   // Result beat {resp, data, timeout}: no-op, answered, or timed out.
   function automatic logic [34:0] expect_result(input logic [3:0] c, input logic [31:0] a,
                                                 input logic [31:0] b, input int lat);
      if (c == 4'h0) return {2'b00, 32'h0, 1'b0};
      if (lat >= 1 && lat <= TIMEOUT) return {calc_model(c, a, b), 1'b0};
      return {2'b00, 32'h0, 1'b1};
   endfunction

   // calc1_top responder: captures cmd/op1/op2, answers lat cycles after op2 (0 = silent).
   int          rsp_wait = 0;
   bit          rsp_phase = 1'b0;
   int          rsp_lat;
   logic [3:0]  seen_cmd;
   logic [31:0] seen_op1;
   logic [1:0]  rsp_val;
   logic [31:0] rsp_dat;

   always @(posedge c_clk) begin
      #1;
      out_resp = 2'b00;
      out_data = 32'h0;
      if (reset) begin
         rsp_phase = 1'b0;
         rsp_wait  = 0;
      end else begin
         if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
               out_resp = rsp_val;
               out_data = rsp_dat;
            end
         end
         if (rsp_phase) begin
            act_req_q.push_back({seen_cmd, seen_op1, req_data_out});
            rsp_phase = 1'b0;
            rsp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            if (rsp_lat > 0) begin
               {rsp_val, rsp_dat} = calc_model(seen_cmd, seen_op1, req_data_out);
               rsp_wait = rsp_lat;
            end
         end
         if (req_cmd_out != 4'h0) begin
            seen_cmd  = req_cmd_out;
            seen_op1  = req_data_out;
            rsp_phase = 1'b1;
         end
         if (cyc == stray_a || cyc == stray_b) begin
            out_resp = 2'b01;
            out_data = 32'hBAD0_BAD0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Call at a falling edge; returns the acceptance edge number in n.
   task automatic push_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input int lat, output int n);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_cmd = c;
      in_op1 = a;
      in_op2 = b;
      while (in_ready !== 1'b1 && guard < 400) begin
         @(negedge c_clk);
         guard++;
      end
      n = cyc + 1;
      if (in_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL push_accept: in_ready=%b after %0d cycles, required 1", in_ready, guard);
         in_valid = 1'b0;
         n = -1;
         return;
      end
      if (c != 4'h0) begin
         lat_q.push_back(lat);
         exp_req_q.push_back({c, a, b});
      end
      exp_q.push_back(expect_result(c, a, b, lat));
      @(negedge c_clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int e);
      e = -1;
      for (int t = 0; t < 40; t++) begin
         @(negedge c_clk);
         if (res_valid === 1'b1) begin
            e = cyc;
            break;
         end
      end
   endtask

   task automatic drain_results(input int n, input int budget);
      int t;
      t = 0;
      while (got_q.size() < n && t < budget) begin
         @(negedge c_clk);
         t++;
         res_ready = ($urandom_range(0, 3) != 0);
         if (res_valid === 1'b1 && res_ready) got_q.push_back({res_resp, res_data, res_timeout});
      end
      @(negedge c_clk);
      res_ready = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      got_q.delete();
      exp_req_q.delete();
      act_req_q.delete();
      lat_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge c_clk);
      vectors++;
      if ({in_ready, busy, res_valid, res_timeout, res_resp} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
         miscompares++;
         $display("FAIL reset_ctrl: ready/busy/valid/to/resp=%b%b%b%b%b required 100000",
                  in_ready, busy, res_valid, res_timeout, res_resp);
      end
      vectors++;
      if ({req_cmd_out, req_data_out, res_data} !== 68'h0) begin
         miscompares++;
         $display("FAIL reset_data: req=%h/%h res_data=%h required all zero",
                  req_cmd_out, req_data_out, res_data);
      end
      reset = 1'b0;
      repeat (2) @(negedge c_clk);
      vectors++;
      if ({in_ready, busy, req_cmd_out} !== {1'b1, 1'b0, 4'h0}) begin
         miscompares++;
         $display("FAIL reset_release: ready=%b busy=%b cmd=%h required 1/0/0", in_ready, busy, req_cmd_out);
      end
   endtask

   task automatic test_addition();
      int n, e;
      logic [34:0] x;
      x = expect_result(4'd1, 32'h5, 32'h1, 2);
      push_txn(4'd1, 32'h5, 32'h1, 2, n);
      @(negedge c_clk);
      vectors++;
      if ({req_cmd_out, req_data_out} !== {4'd1, 32'h5}) begin
         miscompares++;
         $display("FAIL add_send1: req=%h/%h required 1/5", req_cmd_out, req_data_out);
      end
      @(negedge c_clk);
      vectors++;
      if ({req_cmd_out, req_data_out} !== {4'd0, 32'h1}) begin
         miscompares++;
         $display("FAIL add_send2: req=%h/%h required 0/1", req_cmd_out, req_data_out);
      end
      @(negedge c_clk);
      vectors++;
      if ({req_cmd_out, req_data_out, res_valid} !== {4'd0, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL add_wait_entry: req=%h/%h valid=%b required 0/0/0", req_cmd_out, req_data_out, res_valid);
      end
      wait_valid(e);
      vectors++;
      if (e != n + 5) begin
         miscompares++;
         $display("FAIL add_latency: res_valid at N+%0d required N+5", e - n);
      end
      vectors++;
      if ({res_resp, res_data, res_timeout} !== x) begin
         miscompares++;
         $display("FAIL add_fields: %h required %h", {res_resp, res_data, res_timeout}, x);
      end
      drain_results(1, 50);
      vectors++;
      if (got_q.size() != 1 || act_req_q.size() != 1 || act_req_q[0] !== {4'd1, 32'h5, 32'h1}) begin
         miscompares++;
         $display("FAIL add_beat: beats=%0d reqs=%0d required 1/1 with 1/5/1", got_q.size(), act_req_q.size());
      end
      clear_model();
   endtask

   task automatic test_underflow();
      int n, e;
      logic [34:0] x;
      x = expect_result(4'd2, 32'h22, 32'h23, 3);
      push_txn(4'd2, 32'h22, 32'h23, 3, n);
      wait_valid(e);
      vectors++;
      if (e != n + 6 || {res_resp, res_data, res_timeout} !== x) begin
         miscompares++;
         $display("FAIL sub_underflow: edge N+%0d fields %h required N+6 %h", e - n, {res_resp, res_data, res_timeout}, x);
      end
      drain_results(1, 50);
      clear_model();
      x = expect_result(4'd1, 32'hFFFF_FFFF, 32'h1, 1);
      push_txn(4'd1, 32'hFFFF_FFFF, 32'h1, 1, n);
      wait_valid(e);
      vectors++;
      if (e != n + 4 || {res_resp, res_data, res_timeout} !== x) begin
         miscompares++;
         $display("FAIL add_overflow: edge N+%0d fields %h required N+4 %h", e - n, {res_resp, res_data, res_timeout}, x);
      end
      drain_results(1, 50);
      clear_model();
   endtask

   task automatic test_noop();
      int n;
      push_txn(4'd0, 32'h64, 32'h27, 0, n);
      @(negedge c_clk);
      vectors++;
      if ({req_cmd_out, req_data_out} !== {4'd0, 32'h64}) begin
         miscompares++;
         $display("FAIL noop_send1: req=%h/%h required 0/64", req_cmd_out, req_data_out);
      end
      @(negedge c_clk);
      vectors++;
      if ({req_cmd_out, req_data_out, res_valid} !== {4'd0, 32'h27, 1'b0}) begin
         miscompares++;
         $display("FAIL noop_send2: req=%h/%h valid=%b required 0/27/0", req_cmd_out, req_data_out, res_valid);
      end
      @(negedge c_clk);
      vectors++;
      if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL noop_result: valid=%b resp=%b data=%h to=%b at N+3 required 1/00/0/0",
                  res_valid, res_resp, res_data, res_timeout);
      end
      drain_results(1, 50);
      clear_model();
   endtask

   task automatic test_timeout();
      int n, e;
      push_txn(4'd6, 32'hC, 32'h2, 0, n);
      wait_valid(e);
      vectors++;
      if (e != n + 3 + TIMEOUT) begin
         miscompares++;
         $display("FAIL timeout_latency: res_valid at N+%0d required N+%0d", e - n, 3 + TIMEOUT);
      end
      vectors++;
      if ({res_resp, res_data, res_timeout, busy} !== {2'b00, 32'h0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL timeout_fields: resp=%b data=%h to=%b busy=%b required 00/0/1/1",
                  res_resp, res_data, res_timeout, busy);
      end
      drain_results(1, 50);
      clear_model();
   endtask

   task automatic test_stray();
      int n, e;
      logic [3:0] c;
      logic [34:0] x;
      c = 4'($urandom_range(1, 5));
      x = expect_result(c, 32'h11, 32'h22, 0);
      stray_a = cyc + 2;
      push_txn(c, 32'h11, 32'h22, 0, n);
      wait_valid(e);
      vectors++;
      if (e != n + 3 + TIMEOUT || {res_resp, res_data, res_timeout} !== x) begin
         miscompares++;
         $display("FAIL stray_send1: edge N+%0d fields %h required N+%0d %h",
                  e - n, {res_resp, res_data, res_timeout}, 3 + TIMEOUT, x);
      end
      stray_b = cyc + 1;
      repeat (3) @(negedge c_clk);
      vectors++;
      if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, x}) begin
         miscompares++;
         $display("FAIL stray_hold: valid/fields=%h required %h",
                  {res_valid, res_resp, res_data, res_timeout}, {1'b1, x});
      end
      stray_a = -1;
      stray_b = -1;
      drain_results(1, 50);
      clear_model();
   endtask

   task automatic test_backpressure();
      int n, busy_ready;
      logic [34:0] g, x;
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_txn(4'($urandom_range(1, 2)), $urandom(), $urandom(), $urandom_range(1, TIMEOUT), n);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_full: in_ready=%b after 5 accepted, required 0", in_ready);
      end
      in_valid = 1'b1;
      in_cmd = 4'd1;
      busy_ready = 0;
      repeat (8) begin
         @(negedge c_clk);
         if (in_ready !== 1'b0) busy_ready++;
      end
      in_valid = 1'b0;
      vectors++;
      if (busy_ready != 0) begin
         miscompares++;
         $display("FAIL bp_stall: in_ready high on %0d of 8 stalled cycles, required 0", busy_ready);
      end
      fork
         begin
            int m;
            push_txn(4'($urandom_range(1, 3)), $urandom(), $urandom(), $urandom_range(1, TIMEOUT), m);
         end
         drain_results(6, 600);
      join
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (got_q.size() == 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL bp_result[%0d]: beats=%0d expected=%0d, required both non-empty", i, got_q.size(), exp_q.size());
            break;
         end
         g = got_q.pop_front();
         x = exp_q.pop_front();
         if (g !== x) begin
            miscompares++;
            $display("FAIL bp_result[%0d]: got %h required %h", i, g, x);
         end
      end
      repeat (20) @(negedge c_clk);
      vectors++;
      if ({res_valid, busy} !== 2'b00 || act_req_q.size() != 6) begin
         miscompares++;
         $display("FAIL bp_idle: valid=%b busy=%b reqs=%0d required 0/0/6", res_valid, busy, act_req_q.size());
      end
      clear_model();
   endtask

   task automatic test_back_to_back();
      logic [34:0] g, x;
      int bad_req;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               int n;
               push_txn(4'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom_range(0, TIMEOUT), n);
               repeat ($urandom_range(0, 2)) @(negedge c_clk);
            end
         end
         drain_results(16, 3000);
      join
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (got_q.size() == 0 || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL b2b_result[%0d]: beats=%0d expected=%0d, required both non-empty", i, got_q.size(), exp_q.size());
            break;
         end
         g = got_q.pop_front();
         x = exp_q.pop_front();
         if (g !== x) begin
            miscompares++;
            $display("FAIL b2b_result[%0d]: got %h required %h", i, g, x);
         end
      end
      bad_req = 0;
      foreach (exp_req_q[i])
         if (i >= act_req_q.size() || act_req_q[i] !== exp_req_q[i]) bad_req++;
      vectors++;
      if (bad_req != 0 || act_req_q.size() != exp_req_q.size()) begin
         miscompares++;
         $display("FAIL b2b_requests: %0d wrong, %0d seen, required 0 wrong and %0d seen",
                  bad_req, act_req_q.size(), exp_req_q.size());
      end
      clear_model();
   endtask

   task automatic test_reset_mid_wait();
      int n, e, activity;
      logic [34:0] x;
      push_txn(4'd1, $urandom(), $urandom(), 8, n);
      push_txn(4'd2, $urandom(), $urandom(), 1, e);
      push_txn(4'd1, $urandom(), $urandom(), 1, e);
      repeat (3) @(negedge c_clk);
      reset = 1'b1;
      #1;
      vectors++;
      if ({in_ready, busy, res_valid, res_timeout, res_resp, req_cmd_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0}) begin
         miscompares++;
         $display("FAIL midreset_ctrl: ready/busy/valid/to/resp/cmd=%b%b%b%b%b%h required 100000/0",
                  in_ready, busy, res_valid, res_timeout, res_resp, req_cmd_out);
      end
      vectors++;
      if ({req_data_out, res_data} !== 64'h0) begin
         miscompares++;
         $display("FAIL midreset_data: req_data=%h res_data=%h required 0/0", req_data_out, res_data);
      end
      clear_model();
      repeat (2) @(negedge c_clk);
      reset = 1'b0;
      activity = 0;
      repeat (12) begin
         @(negedge c_clk);
         if (req_cmd_out != 4'h0 || req_data_out != 32'h0 || busy || res_valid) activity++;
      end
      vectors++;
      if (activity != 0) begin
         miscompares++;
         $display("FAIL midreset_quiet: %0d active cycles after release, required 0", activity);
      end
      x = expect_result(4'd1, 32'h7, 32'h8, 2);
      push_txn(4'd1, 32'h7, 32'h8, 2, n);
      wait_valid(e);
      vectors++;
      if (e != n + 5 || {res_resp, res_data, res_timeout} !== x) begin
         miscompares++;
         $display("FAIL midreset_recover: edge N+%0d fields %h required N+5 %h", e - n, {res_resp, res_data, res_timeout}, x);
      end
      drain_results(1, 50);
      clear_model();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_addition();
      test_underflow();
      test_noop();
      test_timeout();
      test_stray();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
